// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_pkg
//  Brief   : Shared constants, FSM state type and key sizing helper for the
//            AES byte loader.
//  Rev     : 1.0  initial release
// ============================================================================
package aes_pkg;

    // AES state is always four 32-bit columns
    localparam int NB          = 4;
    localparam int BLOCK_W     = 32 * NB;
    localparam int BLOCK_BYTES = BLOCK_W / 8;

    typedef enum logic [1:0] {
        ST_NOKEY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    // Number of serial bytes that make up a key of nk 32-bit words
    function automatic int key_bytes(input int nk);
        return 4 * nk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : aes_byte_shifter
//  Brief   : Left-shifting byte assembly register with a byte counter.
//            done_o flags the enabled byte that completes COUNT bytes; the
//            counter wraps to zero on that byte. clr_i empties both.
//  Rev     : 1.0  initial release
// ============================================================================
module aes_byte_shifter #(
    parameter  int WIDTH = 128,
    parameter  int COUNT = WIDTH / 8,
    localparam int CW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    cnt_o,
    output logic             done_o
);

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             last_w;

    assign last_w = (cnt_q == CW'(COUNT - 1));
    assign done_o = en_i && !clr_i && last_w;
    assign data_o = data_q;
    assign cnt_o  = cnt_q;

    // Shift the new byte in at the LSB end and advance the byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            data_q <= {data_q[WIDTH-9:0], byte_i};
            cnt_q  <= last_w ? '0 : cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
//  Module  : aes_block_loader
//  Brief   : Assembles a serial byte stream into an AES cipher key (NK words)
//            and 128-bit plaintext blocks, handing completed blocks to the
//            AES core with a valid/ready handshake.
//            Optional feature macro: AES_LOADER_ECHO_EN (last_byte echo).
//  Rev     : 1.0  initial release
// ============================================================================
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int NK = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [32*NK-1:0]  key_out,
    output logic [BLOCK_W-1:0] block_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_valid,
    output logic [7:0]        last_byte
);

    localparam int KEY_W     = 32 * NK;
    localparam int KEY_BYTES = key_bytes(NK);
    localparam int KCW       = $clog2(KEY_BYTES);
    localparam int DCW       = $clog2(BLOCK_BYTES);

    state_e         state_q, state_d;
    logic           key_valid_q, key_valid_d;
    logic           accept;
    logic           key_en, data_en;
    logic           key_done, data_done;
    logic           key_first;
    logic [KCW-1:0] key_cnt;
    logic [DCW-1:0] data_cnt;
    logic           unused_dcnt;

    assign accept    = in_valid && in_ready;
    assign key_en    = accept && in_sel;
    assign data_en   = accept && !in_sel;
    assign key_first = (key_cnt == '0);
    assign unused_dcnt = ^data_cnt;

    aes_byte_shifter #(
        .WIDTH (KEY_W),
        .COUNT (KEY_BYTES)
    ) u_key_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (1'b0),
        .en_i   (key_en),
        .byte_i (in_byte),
        .data_o (key_out),
        .cnt_o  (key_cnt),
        .done_o (key_done)
    );

    // Any key byte discards a partially assembled block
    aes_byte_shifter #(
        .WIDTH (BLOCK_W),
        .COUNT (BLOCK_BYTES)
    ) u_blk_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (key_en),
        .en_i   (data_en),
        .byte_i (in_byte),
        .data_o (block_out),
        .cnt_o  (data_cnt),
        .done_o (data_done)
    );

    // State and key-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_NOKEY;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic; the first byte of a new key always drops to NOKEY
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        case (state_q)
            ST_NOKEY: if (key_done)  state_d = ST_IDLE;
            ST_IDLE:  if (data_en)   state_d = ST_FILL;
            ST_FILL:  if (data_done) state_d = ST_FULL;
            ST_FULL:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_NOKEY;
        endcase
        if (key_en && key_first) begin
            state_d     = ST_NOKEY;
            key_valid_d = 1'b0;
        end
        if (key_done) begin
            key_valid_d = 1'b1;
        end
    end

    // Handshake outputs decoded from state (and in_sel for in_ready)
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            ST_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            ST_NOKEY: in_ready = in_sel;
            default:  in_ready = 1'b1;
        endcase
    end

    assign key_valid = key_valid_q;

`ifdef AES_LOADER_ECHO_EN
    logic [7:0] last_byte_q;

    // Echo every accepted byte for the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_byte_q <= 8'h00;
        end else if (accept) begin
            last_byte_q <= in_byte;
        end
    end

    assign last_byte = last_byte_q;
`else
    assign last_byte = 8'h00;
`endif

endmodule
`default_nettype wire
